compressor_4_2_acc: RTL and testbench
=====================================

COMPRESSOR_4_2_ACC -- requirements
Module: compressor_4_2_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 16: datapath width in bits, minimum 4.
REQ-002 SHALL have parameter BEATS, default 4: accepted operand beats per frame, minimum 1.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port clr, input, 1 bit: synchronous frame abort.
REQ-006 SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-008 SHALL have port in_a, input, WIDTH bits: first partial product.
REQ-009 SHALL have port in_b, input, WIDTH bits: second partial product.
REQ-010 SHALL have port out_valid, output, 1 bit: the frame result is held.
REQ-011 SHALL have port out_ready, output acceptance from the consumer, input, 1 bit.
REQ-012 SHALL have port out_sum, output, WIDTH bits: redundant sum vector.
REQ-013 SHALL have port out_carry, output, WIDTH bits: redundant carry vector.
REQ-014 SHALL have port out_result, output, WIDTH bits: out_sum + out_carry mod 2^WIDTH.

Function
REQ-015 A beat SHALL be accepted on a clock edge with in_valid=1, in_ready=1 and clr=0.
REQ-016 The block SHALL have three states: IDLE, ACC and DONE.
REQ-017 In IDLE and ACC, in_ready SHALL be 1 and out_valid SHALL be 0; in DONE, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-018 Each accepted beat SHALL update registers s_reg and c_reg through one row of WIDTH 4:2 compressor cells.
REQ-019 The compressor cell inputs SHALL be s_reg, c_reg, in_a and in_b.
REQ-020 Column i SHALL receive the intermediate carry of column i-1; column 0 SHALL receive 0; the intermediate carry out of column WIDTH-1 SHALL be dropped.
REQ-021 The new c_reg SHALL be the cell carry vector shifted left by one, with bit 0 = 0 and the MSB dropped.
REQ-022 Invariant: after each accepted beat, (s_reg + c_reg) SHALL equal the mod 2^WIDTH sum of all in_a and in_b accepted in the frame.
REQ-023 The first beat of a frame, accepted in IDLE, SHALL compress with s_reg = c_reg = 0 substituted for the register contents.
REQ-024 A beat counter of width clog2(BEATS+1) SHALL count accepted beats and SHALL reset to 0 on each frame start.
REQ-025 Transitions: IDLE goes to ACC on an accepted beat when BEATS>1.
REQ-026 Transitions: IDLE goes to DONE on an accepted beat when BEATS=1.
REQ-027 Transitions: ACC goes to DONE on the BEATS-th accepted beat.
REQ-028 Transitions: DONE goes to IDLE on out_ready=1.
REQ-029 Latency: out_valid SHALL assert on the cycle after the last beat is accepted.
REQ-030 out_sum, out_carry and out_result SHALL be driven from s_reg and c_reg, and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 out_result SHALL be one combinational WIDTH-bit adder; its carry out SHALL be discarded.
REQ-032 clr=1 SHALL force IDLE, zero the counter and discard the partial frame, from any state.
REQ-033 When clr=1 coincides with in_valid=1, clr SHALL win and no beat SHALL be accepted.
REQ-034 When clr=1 coincides with out_ready=1 in DONE, the block SHALL go to IDLE and the frame SHALL count as discarded.
REQ-035 Outputs SHALL be unaffected by in_a and in_b while out_valid=1.

Reset
REQ-036 While sys_rst_n=0: state = IDLE; s_reg, c_reg and the counter = 0; in_ready = 0; out_valid = 0.
REQ-037 After reset, in_ready SHALL return to 1 from the first clock edge after sys_rst_n deasserts.
REQ-038 Reset mid-frame SHALL discard all accumulated beats.

Structure
REQ-039 The state encoding (IDLE, ACC, DONE) SHALL be in shared package mult_pkg.
REQ-040 The default WIDTH and BEATS constants SHALL be in shared package mult_pkg.
REQ-041 A one-bit sub-module compressor_4_2 SHALL be instantiated WIDTH times via generate.
REQ-042 The compressor_4_2 ports SHALL be i0..i3, ci, co, c, d.

Verification
REQ-043 WIDTH=16, BEATS=4, beats (1,2),(3,4),(5,6),(7,8) back-to-back -> out_valid one cycle after the 4th beat; out_result=36; out_sum+out_carry=36.
REQ-044 WIDTH=16, BEATS=1, beat (0xFFFF,0x0001) -> IDLE goes to DONE; out_result=0x0000.
REQ-045 WIDTH=16, BEATS=4, all operands 0xFFFF -> out_result=0xFFF8.
REQ-046 Frame complete with out_ready=0 for 5 cycles, in_valid held 1 -> in_ready=0; outputs stable; no beat consumed; after out_ready=1, the next beat starts a new frame.
REQ-047 2 beats accepted then clr=1 together with in_valid=1, then frame (10,20)x4 -> out_result=120; the discarded beats do not contribute.
REQ-048 sys_rst_n pulsed low mid-frame after 3 beats -> all outputs 0 asynchronously; next frame (1,1)x4 -> out_result=8.

Source files
------------

// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared state encoding and default sizing for the 4:2
//               compressor accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BEATS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } acc_state_t;

endpackage : mult_pkg

`default_nettype wire

// File: rtl/compressor_4_2.sv
// ============================================================================
// Module      : compressor_4_2
// Description : One-bit 4:2 compressor built from two cascaded full adders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module compressor_4_2 (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic ci,
    output logic co,
    output logic c,
    output logic d
);

    logic w_x;

    // co depends only on i0..i2, so the ci->co path never ripples across a row.
    assign w_x = i0 ^ i1 ^ i2;
    assign co  = (i0 & i1) | (i0 & i2) | (i1 & i2);
    assign d   = w_x ^ i3 ^ ci;
    assign c   = (w_x & i3) | (w_x & ci) | (i3 & ci);

endmodule : compressor_4_2

`default_nettype wire

// File: rtl/compressor_4_2_acc.sv
// ============================================================================
// Module      : compressor_4_2_acc
// Description : Frame accumulator keeping a redundant (sum, carry) total of
//               BEATS operand pairs, resolved by one final adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module compressor_4_2_acc
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BEATS = DEF_BEATS
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_carry,
    output logic [WIDTH-1:0] out_result
);

    localparam int               CNT_W   = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] C_BEATS = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    acc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             rdy_q;

    logic [WIDTH-1:0] w_s_in;
    logic [WIDTH-1:0] w_c_in;
    logic [WIDTH-1:0] w_co;
    logic [WIDTH-1:0] w_cy;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_c_new;
    logic             w_accept;
    logic             unused_carry;

    // A frame's first beat starts from zero, whatever the registers still hold.
    assign w_s_in = (state_q == ST_IDLE) ? '0 : s_q;
    assign w_c_in = (state_q == ST_IDLE) ? '0 : c_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_col
        logic w_ci;
        if (gi == 0) begin : g_lsb
            assign w_ci = 1'b0;
        end else begin : g_mid
            assign w_ci = w_co[gi-1];
        end

        compressor_4_2 u_cell (
            .i0 (w_s_in[gi]),
            .i1 (w_c_in[gi]),
            .i2 (in_a[gi]),
            .i3 (in_b[gi]),
            .ci (w_ci),
            .co (w_co[gi]),
            .c  (w_cy[gi]),
            .d  (w_d[gi])
        );
    end

    // Carries leaving the top column have weight 2^WIDTH and vanish modulo 2^WIDTH.
    assign w_c_new      = {w_cy[WIDTH-2:0], 1'b0};
    assign unused_carry = w_co[WIDTH-1] ^ w_cy[WIDTH-1];

    assign in_ready  = rdy_q && (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign w_accept  = in_valid && in_ready && !clr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        c_d     = c_q;

        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            s_d     = '0;
            c_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        s_d     = w_d;
                        c_d     = w_c_new;
                        cnt_d   = C_ONE;
                        state_d = (BEATS == 1) ? ST_DONE : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        s_d   = w_d;
                        c_d   = w_c_new;
                        cnt_d = cnt_q + C_ONE;
                        if ((cnt_q + C_ONE) == C_BEATS) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            c_q     <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            c_q     <= c_d;
            rdy_q   <= 1'b1;
        end
    end

    assign out_sum    = s_q;
    assign out_carry  = c_q;
    assign out_result = s_q + c_q;

endmodule : compressor_4_2_acc

`default_nettype wire

// File: tb/tb_compressor_4_2_acc.sv
// ============================================================================
// Module      : tb_compressor_4_2_acc
// Description : Directed self-checking bench for compressor_4_2_acc
//               (BEATS=4 main instance, BEATS=1 second instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_compressor_4_2_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid, in_ready;
    logic [15:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [15:0] out_sum, out_carry, out_result;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [15:0] out_sum1, out_carry1, out_result1;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [15:0] w_tot;

    always #5 clk = ~clk;

    compressor_4_2_acc #(.WIDTH(16), .BEATS(4)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_result(out_result)
    );

    compressor_4_2_acc #(.WIDTH(16), .BEATS(1)) dut1 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .clr       (1'b0),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_sum   (out_sum1),
        .out_carry (out_carry1),
        .out_result(out_result1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_in_ready1", in_ready1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // (1,2)..(7,8) back to back -> 36
        send(16'd1, 16'd2);
        send(16'd3, 16'd4);
        send(16'd5, 16'd6);
        chk("f1_not_yet_valid", out_valid, 0);
        send(16'd7, 16'd8);
        chk("f1_out_valid", out_valid, 1);
        chk("f1_in_ready", in_ready, 0);
        chk("f1_out_result", out_result, 36);
        w_tot = out_sum + out_carry;
        chk("f1_sum_plus_carry", w_tot, 36);
        take();
        chk("f1_released", out_valid, 0);

        // all-ones operands wrap to 0xFFF8
        repeat (4) send(16'hFFFF, 16'hFFFF);
        chk("ones_out_valid", out_valid, 1);
        chk("ones_out_result", out_result, 16'hFFF8);
        take();

        // BEATS=1 instance: single beat completes the frame
        in_valid1 = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001;
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("b1_out_valid", out_valid1, 1);
        chk("b1_in_ready", in_ready1, 0);
        chk("b1_out_result", out_result1, 0);
        in_a = 16'h1234; in_b = 16'h4321;
        @(negedge clk);
        chk("b1_hold_result", out_result1, 0);
        w_tot = out_sum1 + out_carry1;
        chk("b1_hold_sc", w_tot, 0);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("b1_released", out_valid1, 0);

        // backpressure: frame held while in_valid stays high
        repeat (4) send(16'd2, 16'd3);
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_result", out_result, 20);
            w_tot = out_sum + out_carry;
            chk("bp_sum_plus_carry", w_tot, 20);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_released", out_valid, 0);
        chk("bp_ready_again", in_ready, 1);
        send(16'h1111, 16'h2222);
        repeat (3) send(16'd1, 16'd1);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_result", out_result, 16'h3339);
        take();

        // clr with in_valid mid-frame discards the partial frame
        send(16'd100, 16'd200);
        send(16'd300, 16'd400);
        clr = 1'b1; in_valid = 1'b1; in_a = 16'd5; in_b = 16'd5;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_in_ready", in_ready, 1);
        chk("clr_out_valid", out_valid, 0);
        repeat (3) send(16'd10, 16'd20);
        chk("clr_not_early", out_valid, 0);
        send(16'd10, 16'd20);
        chk("clr_frame_valid", out_valid, 1);
        chk("clr_frame_result", out_result, 120);
        take();

        // clr together with out_ready in DONE
        repeat (4) send(16'd9, 16'd9);
        clr = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0; out_ready = 1'b0;
        chk("clr_done_idle", out_valid, 0);
        chk("clr_done_result", out_result, 0);

        // asynchronous reset mid-frame
        repeat (3) send(16'd7, 16'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_sum", out_sum, 0);
        chk("arst_out_carry", out_carry, 0);
        chk("arst_out_result", out_result, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready_back", in_ready, 1);
        repeat (3) send(16'd1, 16'd1);
        chk("arst_not_early", out_valid, 0);
        send(16'd1, 16'd1);
        chk("arst_frame_valid", out_valid, 1);
        chk("arst_frame_result", out_result, 8);
        take();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_compressor_4_2_acc

`default_nettype wire
